fix_initiator_dut: RTL and testbench

//  - Minimal FIX-style session initiator. After a configure pulse and a start pulse it transmits a Logon message.
//  - Parses bytes received from the acceptor and answers Logon, Heartbeat and Test Request with a Heartbeat, and Logout with a Logout.
//  - Byte-serial ASCII in/out. Sits between the acceptor link and the order-handling logic.

---
 rtl/fix_initiator_dut.sv | 173 +++++++++++++++++
 tb/tb_fix_initiator_dut.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fix_initiator_dut.sv
// Minimal FIX-style session initiator: sends Logon on start, parses acceptor messages
// and answers Logon/Heartbeat/TestRequest with Heartbeat and Logout with Logout.
module fix_initiator_dut #(
    parameter int HB_INT = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       start,
    input  logic       configure,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       valid
);

    typedef enum logic [2:0] {
        IDLE, READY, SEND_LOGON, ACTIVE, SEND_HB, SEND_LO, DONE
    } state_t;

    // Response codes are ordered so that the larger value wins a collision.
    localparam logic [1:0] RSP_NONE = 2'd0;
    localparam logic [1:0] RSP_HB   = 2'd1;
    localparam logic [1:0] RSP_LO   = 2'd2;

    localparam logic [2:0] F_T0   = 3'd0;
    localparam logic [2:0] F_T1   = 3'd1;
    localparam logic [2:0] F_T2   = 3'd2;
    localparam logic [2:0] F_CAP  = 3'd3;
    localparam logic [2:0] F_SKIP = 3'd4;

    localparam logic [7:0] HB_D1 = 8'(48 + HB_INT / 10);
    localparam logic [7:0] HB_D0 = 8'(48 + HB_INT % 10);

    localparam logic [95:0] LOGON_STR = {8'h33, 8'h35, 8'h3D, 8'h41, 8'h7C, 8'h31,
                                         8'h30, 8'h38, 8'h3D, HB_D1, HB_D0, 8'h3B};
    localparam logic [39:0] HB_STR    = {8'h33, 8'h35, 8'h3D, 8'h30, 8'h3B};
    localparam logic [39:0] LO_STR    = {8'h33, 8'h35, 8'h3D, 8'h35, 8'h3B};

    logic [7:0] logon_rom [0:11];
    logic [7:0] hb_rom    [0:4];
    logic [7:0] lo_rom    [0:4];

    genvar gi;
    generate
        for (gi = 0; gi < 12; gi++) begin : g_logon
            assign logon_rom[gi] = LOGON_STR[95 - 8*gi -: 8];
        end
        for (gi = 0; gi < 5; gi++) begin : g_short
            assign hb_rom[gi] = HB_STR[39 - 8*gi -: 8];
            assign lo_rom[gi] = LO_STR[39 - 8*gi -: 8];
        end
    endgenerate

    state_t     state_reg;
    logic [3:0] idx_reg;
    logic [1:0] pending_reg;
    logic [2:0] fpos_reg;
    logic [7:0] msg_type_reg;

    logic       parse_on;
    logic       term;
    logic [1:0] rsp_now;
    logic [1:0] pend_next;
    logic [3:0] cur_len;
    logic [7:0] cur_byte;

    assign parse_on = (state_reg == SEND_LOGON) || (state_reg == ACTIVE) || (state_reg == SEND_HB);
    assign term     = parse_on && enable && (din == 8'h3B);

    always_comb begin
        rsp_now = RSP_NONE;
        if (term) begin
            case (msg_type_reg)
                8'h30, 8'h31, 8'h41: rsp_now = RSP_HB;
                8'h35:               rsp_now = RSP_LO;
                default:             rsp_now = RSP_NONE;
            endcase
        end
        pend_next = (rsp_now > pending_reg) ? rsp_now : pending_reg;
    end

    always_comb begin
        cur_len  = (state_reg == SEND_LOGON) ? 4'd12 : 4'd5;
        cur_byte = 8'h00;
        case (state_reg)
            SEND_LOGON: if (idx_reg < 4'd12) cur_byte = logon_rom[idx_reg];
            SEND_HB:    if (idx_reg < 4'd5)  cur_byte = hb_rom[idx_reg[2:0]];
            SEND_LO:    if (idx_reg < 4'd5)  cur_byte = lo_rom[idx_reg[2:0]];
            default:    cur_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            idx_reg      <= 4'd0;
            pending_reg  <= RSP_NONE;
            fpos_reg     <= F_T0;
            msg_type_reg <= 8'h00;
            dout         <= 8'h00;
            valid        <= 1'b0;
        end else begin
            // Field parser: looks for a "35=" field and captures the byte after it.
            if (parse_on && enable) begin
                if (din == 8'h3B) begin
                    fpos_reg     <= F_T0;
                    msg_type_reg <= 8'h00;
                end else if (din == 8'h7C) begin
                    fpos_reg <= F_T0;
                end else begin
                    case (fpos_reg)
                        F_T0:  fpos_reg <= (din == 8'h33) ? F_T1 : F_SKIP;
                        F_T1:  fpos_reg <= (din == 8'h35) ? F_T2 : F_SKIP;
                        F_T2:  fpos_reg <= (din == 8'h3D) ? F_CAP : F_SKIP;
                        F_CAP: begin
                            msg_type_reg <= din;
                            fpos_reg     <= F_SKIP;
                        end
                        default: fpos_reg <= F_SKIP;
                    endcase
                end
            end

            case (state_reg)
                IDLE: begin
                    if (configure) state_reg <= READY;
                end
                READY: begin
                    if (start) begin
                        state_reg <= SEND_LOGON;
                        dout      <= 8'h33;
                        valid     <= 1'b1;
                        idx_reg   <= 4'd1;
                    end
                end
                SEND_LOGON, SEND_HB, SEND_LO: begin
                    if (idx_reg != cur_len) begin
                        dout        <= cur_byte;
                        idx_reg     <= idx_reg + 4'd1;
                        pending_reg <= pend_next;
                    end else if (state_reg != SEND_LO && pend_next != RSP_NONE) begin
                        // Back-to-back: the queued response follows without a gap.
                        state_reg   <= (pend_next == RSP_LO) ? SEND_LO : SEND_HB;
                        dout        <= 8'h33;
                        valid       <= 1'b1;
                        idx_reg     <= 4'd1;
                        pending_reg <= RSP_NONE;
                    end else begin
                        state_reg   <= (state_reg == SEND_LO) ? DONE : ACTIVE;
                        dout        <= 8'h00;
                        valid       <= 1'b0;
                        idx_reg     <= 4'd0;
                        pending_reg <= pend_next;
                    end
                end
                ACTIVE: begin
                    if (pend_next != RSP_NONE) begin
                        state_reg   <= (pend_next == RSP_LO) ? SEND_LO : SEND_HB;
                        dout        <= 8'h33;
                        valid       <= 1'b1;
                        idx_reg     <= 4'd1;
                        pending_reg <= RSP_NONE;
                    end
                end
                default: begin
                    dout  <= 8'h00;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fix_initiator_dut.sv
// Randomized bench for fix_initiator_dut against a string/queue-level session model,
// checking valid and dout every cycle.
module tb_fix_initiator_dut;

    localparam int HB = 30;

    logic       clk = 1'b0;
    logic       reset, enable, start, configure;
    logic [7:0] din;
    logic [7:0] dout;
    logic       valid;

    fix_initiator_dut #(.HB_INT(HB)) dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start),
        .configure(configure), .din(din), .dout(dout), .valid(valid)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    // Model: phase 0 idle, 1 ready, 2 session open, 3 done.
    // Message kinds: 1 heartbeat, 2 logout, 3 logon.
    int         m_phase;
    bit         m_show;
    int         m_kind;
    logic [7:0] m_cur;
    logic [7:0] m_q[$];
    int         m_pending;
    logic [7:0] m_rx[$];
    int         done_cnt;

    logic [7:0] rx_q[$];
    string      msgs[10] = '{"35=1;", "35=0;", "35=A;", "49=X|35=1;", "35=Z;",
                             "8=FIX|35=A|34=2;", "3=5;", "35=;", "335=1;", "35=5;"};

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s cycle %0d: got %02h expected %02h", tag, cyc, got, exp);
    endtask

    function automatic int classify(input logic [7:0] b[$]);
        int         fs = 0;
        logic [7:0] t = 8'h00;
        for (int i = 0; i <= b.size(); i++) begin
            if (i == b.size() || b[i] == 8'h7C) begin
                if (i - fs >= 4 && b[fs] == "3" && b[fs+1] == "5" && b[fs+2] == "=")
                    t = b[fs+3];
                fs = i + 1;
            end
        end
        if (t == "0" || t == "1" || t == "A") return 1;
        if (t == "5") return 2;
        return 0;
    endfunction

    task automatic load(input int k);
        string s;
        if (k == 3)      s = $sformatf("35=A|108=%02d;", HB);
        else if (k == 1) s = "35=0;";
        else             s = "35=5;";
        m_q.delete();
        for (int i = 0; i < s.len(); i++) m_q.push_back(s[i]);
        m_cur   = m_q.pop_front();
        m_show  = 1'b1;
        m_kind  = k;
        m_phase = 2;
        $display("tx start cycle %0d kind %0d msg %s", cyc, k, s);
    endtask

    task automatic model_step(input logic r, c, s, e, input logic [7:0] d);
        int rsp, merged;
        if (r) begin
            m_phase = 0; m_show = 1'b0; m_kind = 0; m_cur = 8'h00;
            m_q.delete(); m_pending = 0; m_rx.delete(); done_cnt = 0;
            return;
        end
        rsp = 0;
        if (m_phase == 2 && !(m_show && m_kind == 2) && e) begin
            if (d == 8'h3B) begin
                rsp = classify(m_rx);
                m_rx.delete();
            end else begin
                m_rx.push_back(d);
            end
        end
        merged = (rsp > m_pending) ? rsp : m_pending;
        case (m_phase)
            0: if (c) m_phase = 1;
            1: if (s) load(3);
            2: begin
                if (m_show && m_q.size() > 0) begin
                    m_cur = m_q.pop_front();
                    m_pending = merged;
                end else if (m_show) begin
                    if (m_kind == 2) begin
                        m_show = 1'b0; m_phase = 3;
                    end else if (merged != 0) begin
                        load(merged); m_pending = 0;
                    end else begin
                        m_show = 1'b0; m_pending = 0;
                    end
                end else if (merged != 0) begin
                    load(merged); m_pending = 0;
                end
            end
            default: done_cnt++;
        endcase
    endtask

    task automatic cycle(input logic r, c, s, e, input logic [7:0] d);
        reset = r; configure = c; start = s; enable = e; din = d;
        @(posedge clk);
        cyc++;
        model_step(r, c, s, e, d);
        #1;
        check("valid", {7'b0, valid}, {7'b0, m_show});
        check("dout", dout, m_show ? m_cur : 8'h00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic feed(input string s);
        for (int i = 0; i < s.len(); i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1, s[i]);
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom));
        end
    endtask

    initial begin
        logic r, c, s, e;
        logic [7:0] b;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        idle(3);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        feed("35=1;");
        idle(20);
        feed("35=1;");
        idle(10);
        feed("35=5;");
        idle(10);
        feed("35=1;");
        idle(10);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        idle(4);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        idle(2);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        idle(15);

        for (int n = 0; n < 4000; n++) begin
            r = ($urandom_range(0, 299) == 0) || (m_phase == 3 && done_cnt > 15);
            c = ($urandom_range(0, 9) == 0);
            s = ($urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 1) == 1);
            if (e) begin
                if (rx_q.size() == 0) begin
                    string m;
                    m = msgs[$urandom_range(0, 9)];
                    for (int i = 0; i < m.len(); i++) rx_q.push_back(m[i]);
                end
                b = rx_q.pop_front();
            end else begin
                b = 8'($urandom);
            end
            cycle(r, c, s, e, b);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
